// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, word width and default reset PC.
package pc_fetch_unit_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StFetch  = 2'd1,
      StHold   = 2'd2,
      StHalted = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction memory req/ack on one side, decode valid/ready on the other.
interface pc_fetch_unit_if;
   import pc_fetch_unit_pkg::*;

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_rdata;
   logic [WORD_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_rdata, instr_ready
   );

endinterface

// File: rtl/pc_fetch_unit_timeout.sv
// Counts consecutive un-acked fetch cycles; o_expired flags the last cycle before giving up.
module fetch_timeout_counter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] r_count;
   logic             w_expired;

   assign w_expired = (r_count == CNT_W'(TIMEOUT - 1));
   assign o_expired = w_expired;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: fetches one instruction per PC over req/ack and hands it to decode.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned       TIMEOUT  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [WORD_W-1:0] i_next_address,
   input  logic              i_halt,
   input  logic              i_resume,
   output logic [WORD_W-1:0] o_pc_out,
   output logic              o_halted,
   output logic              o_fetch_error,
   output logic [WORD_W-1:0] o_retired_count,
   pc_fetch_unit_if.master   bus
);

   fetch_state_e      r_state;
   logic [WORD_W-1:0] r_pc;
   logic [WORD_W-1:0] r_instr;
   logic [WORD_W-1:0] r_retired;
   logic              r_imem_req;
   logic              r_instr_valid;
   logic              r_halted;
   logic              r_fetch_error;
   logic              w_timer_en;
   logic              w_timer_clr;
   logic              w_expired;

   // Count only un-acked FETCH cycles; any ack or state change restarts the window.
   assign w_timer_en  = (r_state == StFetch) && !bus.imem_ack;
   assign w_timer_clr = (r_state != StFetch) || bus.imem_ack;

   fetch_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_enable  (w_timer_en),
      .i_clear   (w_timer_clr),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_retired     <= '0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_fetch_error <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_state    <= StFetch;
               r_imem_req <= 1'b1;
            end
            StFetch: begin
               // An ack in the expiry cycle takes priority over the timeout.
               if (bus.imem_ack) begin
                  r_instr       <= bus.imem_rdata;
                  r_instr_valid <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_state       <= StHold;
               end else if (w_expired) begin
                  r_fetch_error <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_halted      <= 1'b1;
                  r_state       <= StHalted;
               end
            end
            StHold: begin
               if (bus.instr_ready) begin
                  r_pc          <= i_next_address;
                  r_retired     <= r_retired + 1'b1;
                  r_instr_valid <= 1'b0;
                  if (i_halt) begin
                     r_halted <= 1'b1;
                     r_state  <= StHalted;
                  end else begin
                     r_imem_req <= 1'b1;
                     r_state    <= StFetch;
                  end
               end
            end
            StHalted: begin
               if (i_resume && !r_fetch_error) begin
                  r_halted   <= 1'b0;
                  r_imem_req <= 1'b1;
                  r_state    <= StFetch;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_pc_out        = r_pc;
   assign o_halted        = r_halted;
   assign o_fetch_error   = r_fetch_error;
   assign o_retired_count = r_retired;

   assign bus.imem_req    = r_imem_req;
   assign bus.imem_addr   = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_valid = r_instr_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit against a transaction-level PC/retire model.
module tb_pc_fetch_unit;
   import pc_fetch_unit_pkg::*;

   localparam int unsigned TIMEOUT = 16;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] next_address;
   logic        halt;
   logic        resume;
   logic [31:0] pc_out;
   logic        halted;
   logic        fetch_error;
   logic [31:0] retired_count;

   pc_fetch_unit_if bus ();

   pc_fetch_unit #(
      .RESET_PC (RST_PC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_next_address  (next_address),
      .i_halt          (halt),
      .i_resume        (resume),
      .o_pc_out        (pc_out),
      .o_halted        (halted),
      .o_fetch_error   (fetch_error),
      .o_retired_count (retired_count),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc;
   logic [31:0] m_ret;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expects the DUT to be requesting at m_pc; runs one full fetch/decode transaction.
   task automatic txn(input int lat, input logic [31:0] data, input int stall,
                      input logic [31:0] nxt, input bit do_halt);
      chk("req_at_start", 32'(bus.imem_req), 32'd1);
      chk("addr_at_start", bus.imem_addr, m_pc);
      for (int i = 0; i < lat; i++) begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = $urandom;
         tick();
         chk("req_held", 32'(bus.imem_req), 32'd1);
         chk("addr_held", bus.imem_addr, m_pc);
      end
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = data;
      bus.instr_ready = (stall == 0);
      next_address    = nxt;
      tick();
      bus.imem_ack = 1'b0;
      chk("valid_after_ack", 32'(bus.instr_valid), 32'd1);
      chk("instr_after_ack", bus.instr, data);
      chk("req_after_ack", 32'(bus.imem_req), 32'd0);
      for (int i = 0; i < stall; i++) begin
         bus.instr_ready = 1'b0;
         halt            = 1'($urandom_range(1, 0));
         bus.imem_ack    = 1'($urandom_range(1, 0));
         bus.imem_rdata  = $urandom;
         next_address    = $urandom;
         tick();
         chk("stall_instr", bus.instr, data);
         chk("stall_valid", 32'(bus.instr_valid), 32'd1);
         chk("stall_pc", pc_out, m_pc);
         chk("stall_retired", retired_count, m_ret);
      end
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b1;
      next_address    = nxt;
      halt            = do_halt;
      tick();
      bus.instr_ready = 1'b0;
      halt            = 1'b0;
      m_pc  = nxt;
      m_ret = m_ret + 1;
      chk("hs_pc", pc_out, m_pc);
      chk("hs_retired", retired_count, m_ret);
      chk("hs_valid", 32'(bus.instr_valid), 32'd0);
      chk("hs_halted", 32'(halted), 32'(do_halt));
      chk("hs_req", 32'(bus.imem_req), 32'(!do_halt));
      if (!do_halt) chk("hs_next_addr", bus.imem_addr, nxt);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      m_pc  = RST_PC;
      m_ret = '0;
   endtask

   initial begin
      int          req_cycles;
      logic [31:0] r;

      rst = 1'b1; next_address = '0; halt = 1'b0; resume = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
      tick();
      tick();
      chk("rst_pc", pc_out, RST_PC);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, RST_PC);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_error", 32'(fetch_error), 32'd0);
      chk("rst_retired", retired_count, 32'd0);
      rst  = 1'b0;
      m_pc  = RST_PC;
      m_ret = '0;
      tick();
      chk("first_req_latency", 32'(bus.imem_req), 32'd1);

      // Immediate ack, sequential advance
      txn(0, 32'hDEAD_BEEF, 0, 32'd1, 1'b0);
      // Walk to PC 5, then branch to 0x40
      while (m_pc != 32'd5) txn($urandom_range(3, 0), $urandom, $urandom_range(2, 0), m_pc + 1, 1'b0);
      txn(1, $urandom, 0, 32'h40, 1'b0);
      // Delayed ack with long decode stall
      txn(3, 32'hCAFE_F00D, 7, m_pc + 1, 1'b0);
      // Ack in the very last cycle before timeout must win
      txn(TIMEOUT - 1, 32'h1234_5678, 1, m_pc + 1, 1'b0);
      chk("late_ack_no_error", 32'(fetch_error), 32'd0);
      for (int n = 0; n < 8; n++) begin
         txn($urandom_range(TIMEOUT - 1, 0), $urandom, $urandom_range(4, 0), $urandom, 1'b0);
      end

      // Halt on handshake, stale acks ignored, resume restarts at the loaded PC
      r = $urandom;
      txn(2, $urandom, 1, r, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = $urandom;
         tick();
         chk("halt_req", 32'(bus.imem_req), 32'd0);
         chk("halt_valid", 32'(bus.instr_valid), 32'd0);
         chk("halt_pc", pc_out, m_pc);
      end
      bus.imem_ack = 1'b0;
      resume       = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 32'd0);
      txn(0, $urandom, 0, m_pc + 1, 1'b0);

      // Reset mid-fetch at address 9, then a late ack
      do_reset();
      tick();
      txn(0, $urandom, 0, 32'd9, 1'b0);
      rst          = 1'b1;
      bus.imem_ack = 1'b1;
      tick();
      rst = 1'b0;
      m_pc  = RST_PC;
      m_ret = '0;
      chk("midrst_req", 32'(bus.imem_req), 32'd0);
      chk("midrst_pc", pc_out, RST_PC);
      chk("midrst_retired", retired_count, 32'd0);
      tick();
      bus.imem_ack = 1'b0;
      chk("late_ack_valid", 32'(bus.instr_valid), 32'd0);
      chk("late_ack_req", 32'(bus.imem_req), 32'd1);

      // Timeout: count FETCH cycles with req high, bounded
      req_cycles = 1;
      for (int i = 0; i < 40 && bus.imem_req; i++) begin
         tick();
         if (bus.imem_req) req_cycles++;
      end
      chk("timeout_cycles", 32'(req_cycles), 32'(TIMEOUT));
      chk("timeout_error", 32'(fetch_error), 32'd1);
      chk("timeout_halted", 32'(halted), 32'd1);
      resume = 1'b1;
      tick();
      tick();
      resume = 1'b0;
      chk("resume_ignored_req", 32'(bus.imem_req), 32'd0);
      chk("resume_ignored_halt", 32'(halted), 32'd1);
      do_reset();
      chk("rst_clears_error", 32'(fetch_error), 32'd0);
      chk("rst_clears_halted", 32'(halted), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and drives its value to the jump unit as PCin.
- Fetches one instruction per PC from a variable-latency instruction memory using a req/ack handshake, then presents it to decode with a valid/ready handshake.
- On each decode handshake it loads the PC from the jump unit's next_address.
- Single-issue, one instruction in flight. Includes a fetch timeout and halt/resume control.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address; sequential PC advances by 1).
- TIMEOUT, 16, cycles to wait for imem_ack before flagging a fetch error (must be >= 2).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- next_address  in  32  next PC from jump unit (PC+1 or branch/jump target)
- halt  in  1  stop after the instruction currently being handed to decode
- resume  in  1  leave HALTED and restart fetch at current PC
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr_ready  in  1  decode accepts instr this cycle
- pc_out  out  32  current PC, feeds jump unit PCin
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc_out while imem_req=1)
- instr  out  32  latched instruction word
- instr_valid  out  1  instr holds an unconsumed instruction
- halted  out  1  high while in HALTED
- fetch_error  out  1  sticky, set on timeout, cleared only by rst
- retired_count  out  32  number of decode handshakes since reset, wraps at 2^32

Behaviour:
- Reset: one clock, synchronous and active-high. rst sampled high gives state=IDLE, pc_out=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, halted=0, fetch_error=0, retired_count=0, timeout counter=0. rst overrides all other inputs.
- States: IDLE, FETCH, HOLD, HALTED. All outputs are registered.
- IDLE:
  - Next cycle goes to FETCH.
  - Minimum latency is 1 cycle from reset release to imem_req=1.
- FETCH:
  - imem_req=1 and imem_addr=pc_out, both stable until ack.
  - imem_ack=1: instr <= imem_rdata, instr_valid=1 on the next cycle, imem_req=0, state becomes HOLD.
  - Fastest case (ack in the first FETCH cycle): instr_valid rises 1 cycle after imem_req rises.
- Timeout:
  - The counter increments each FETCH cycle without ack and resets on ack or on leaving FETCH.
  - When the counter reaches TIMEOUT-1 with no ack: fetch_error <= 1, imem_req <= 0, state becomes HALTED.
  - An ack arriving in that same cycle wins: no error is raised.
- HOLD:
  - instr_valid=1; instr is held stable while instr_ready=0 (stall of any length).
  - Handshake (instr_valid & instr_ready): pc_out <= next_address, retired_count += 1, instr_valid <= 0.
  - After the handshake, state becomes HALTED if halt=1 in that cycle, else FETCH.
  - halt while instr_ready=0 has no effect.
- HALTED:
  - halted=1, imem_req=0.
  - resume=1 takes the state to FETCH with the current pc_out, and clears halted on the next cycle.
  - resume has no effect after a timeout while fetch_error=1 (stays HALTED until rst).
- Ignored inputs:
  - imem_ack in IDLE, HOLD or HALTED is ignored (stale responses, e.g. after reset mid-fetch).
  - resume outside HALTED and halt outside a HOLD handshake are ignored.
- Arithmetic and width:
  - next_address is taken verbatim, 32-bit with no alignment check.
  - PC wrap from 32'hFFFF_FFFF to 0 is the jump unit's business; this block just loads it.
  - retired_count wraps silently.
- Reset mid-operation: rst during FETCH drops imem_req on the next edge, and memory must tolerate an abandoned request. rst during HOLD discards instr.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, HALTED=2'd3).
  - The default RESET_PC.
  - The 32-bit word-width constant shared with jump unit and ALU.
- One sub-module: fetch_timeout_counter (clk, rst, enable, clear, expired), parameterised by TIMEOUT.
- The rest is a single FSM-plus-datapath module.

Test Plan:
- Reset then immediate ack, RESET_PC=0, imem_rdata=32'hDEAD_BEEF, instr_ready=1, next_address=1 -> imem_addr=0, instr=DEAD_BEEF valid one cycle after req, then pc_out=1, retired_count=1, and a new req at addr 1.
- Branch: in HOLD with pc_out=5, next_address=32'h40 at handshake -> next imem_addr=32'h40, no fetch of 6.
- Stall: instr_ready low for 7 cycles with ack delayed 3 cycles -> instr stable throughout, pc_out unchanged, retired_count advances exactly once on the ready cycle.
- Timeout: TIMEOUT=16, no ack -> imem_req drops and fetch_error=1, halted=1 after 16 FETCH cycles; resume ignored; rst clears both.
- Halt/resume: halt=1 with handshake at pc 3, next_address=4 -> HALTED, pc_out=4, no req; stale imem_ack ignored; resume -> req at addr 4 next cycle.
- Reset mid-fetch: rst asserted while imem_req=1 at addr 9 -> next cycle imem_req=0, pc_out=RESET_PC, and a late ack does not set instr_valid.
